// File: rtl/elastic_credit_sender.sv
// Credit-based sender: forwards valid/ready tokens as registered valid-only pulses.
// Optional sticky overflow flag via ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN.
module elastic_credit_sender #(
    parameter int DATA_SIZE = 32,
    parameter int CREDITS   = 8,
    localparam int CW       = $clog2(CREDITS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 credit_in,
    output logic [CW-1:0]        credit_count,
`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
    output logic                 credit_err,
`endif
    output logic                 idle
);

    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic send;
    logic full;
    logic overflow;

    assign full     = (credit_count == MAX);
    assign ready_in = (credit_count != '0);
    assign send     = valid_in & ready_in;
    assign overflow = credit_in & ~send & full;
    assign idle     = full & ~valid_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= send;
            if (send)
                data_out <= data_in;
        end
    end

    // A credit arriving while full is dropped so the count saturates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_count <= MAX;
        end else begin
            unique case ({send, credit_in})
                2'b10:   credit_count <= credit_count - 1'b1;
                2'b01:   if (!full) credit_count <= credit_count + 1'b1;
                default: credit_count <= credit_count;
            endcase
        end
    end

`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credit_err <= 1'b0;
        else if (overflow)
            credit_err <= 1'b1;
    end
`else
    logic unused_overflow;
    assign unused_overflow = overflow;
`endif

endmodule

// File: tb/tb_elastic_credit_sender.sv
// Scoreboard bench for elastic_credit_sender with a behavioural credit model.
// Honours ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN when defined.
module tb_elastic_credit_sender;

    localparam int DW = 32;
    localparam int CR = 8;
    localparam int CW = $clog2(CR + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          credit_in = 1'b0;
    logic [CW-1:0] credit_count;
    logic          idle;
`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
    logic          credit_err;
`endif

    elastic_credit_sender #(.DATA_SIZE(DW), .CREDITS(CR)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .valid_in(valid_in),
        .ready_in(ready_in),
        .data_out(data_out),
        .valid_out(valid_out),
        .credit_in(credit_in),
        .credit_count(credit_count),
`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
        .credit_err(credit_err),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Reference model state: available credits as a plain integer.
    int m_cred = CR;
    bit m_vout = 0;
    bit m_err  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missing_token", 64'(exp_q[0].data), 64'hDEAD);
                void'(exp_q.pop_front());
            end
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_token", 64'(data_out), 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("data_out", 64'(data_out), 64'(e.data));
                    chk("token_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic check_state();
        chk("credit_count", 64'(credit_count), 64'(m_cred));
        chk("ready_in", 64'(ready_in), 64'(m_cred > 0));
        chk("valid_out", 64'(valid_out), 64'(m_vout));
        chk("idle", 64'(idle), 64'(m_cred == CR && !m_vout));
`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
        chk("credit_err", 64'(credit_err), 64'(m_err));
`endif
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit c, output bit s);
        @(negedge clk);
        check_state();
        valid_in  = v;
        data_in   = d;
        credit_in = c;
        s = v && (m_cred > 0);
        if (s)
            exp_q.push_back('{d, cyc + 1});
        if (s && !c)
            m_cred--;
        else if (c && !s) begin
            if (m_cred == CR) m_err = 1;
            else m_cred++;
        end
        m_vout = s;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        valid_in = 1'b0;
        credit_in = 1'b0;
        #1;
        chk("rst_valid_out", 64'(valid_out), 64'h0);
        chk("rst_data_out", 64'(data_out), 64'h0);
        chk("rst_credit_count", 64'(credit_count), 64'(CR));
        chk("rst_ready_in", 64'(ready_in), 64'h1);
        chk("rst_idle", 64'(idle), 64'h1);
`ifdef ELASTIC_CREDIT_SENDER_CREDIT_CHECK_EN
        chk("rst_credit_err", 64'(credit_err), 64'h0);
`endif
        exp_q.delete();
        m_cred = CR;
        m_vout = 0;
        m_err  = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    bit s;
    bit hist[$];

    initial begin
        #12;
        rst = 1'b0;

        // Burst drain, then starvation recovery.
        for (int i = 1; i <= 10; i++)
            step(1, DW'(i), 0, s);
        step(1, 9, 1, s);
        step(1, 9, 0, s);
        step(0, 0, 0, s);
        chk("drained_count", 64'(credit_count), 64'h0);

        // Raise to 3, then send and credit together.
        for (int i = 0; i < 3; i++)
            step(0, 0, 1, s);
        step(1, 32'hABC, 1, s);
        step(0, 0, 0, s);
        chk("simul_count", 64'(credit_count), 64'h3);

        // Token in flight discarded by mid-cycle reset.
        do_reset();
        step(1, 32'h55, 0, s);
        do_reset();

        // Overflow at full count.
        step(0, 0, 1, s);
        step(0, 0, 0, s);
        step(0, 0, 0, s);
        do_reset();

        // Steady state: credits looped back four cycles after each send.
        hist.delete();
        for (int i = 0; i < 40; i++) begin
            bit c;
            c = (hist.size() >= 4) ? hist[hist.size() - 4] : 1'b0;
            step(1, $urandom, c, s);
            hist.push_back(s);
        end
        chk("steady_count", 64'(credit_count), 64'h4);
        do_reset();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, s);
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, s);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

endmodule
